// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port round-robin arbiter and sequencer in front of the
//               single-ported data memory. Port 0 is the CPU load/store unit
//               and port 1 is the debug/DMA loader. Each grant becomes one
//               memory command. Out-of-range addresses are rejected without
//               touching memory.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ack,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_stall,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              cmd_id_q;
  logic              cmd_we_q;
  logic              cmd_err_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic              last_grant_q;
  logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;

  logic              w_any_req;
  logic              w_grant_id;
  logic              w_grant_we;
  logic [ADDR_W-1:0] w_grant_addr;
  logic [DATA_W-1:0] w_grant_wdata;
  logic              w_addr_err;

  // Port 1 wins when alone, or on a conflict when port 0 was granted last.
  assign w_any_req     = p0_req | p1_req;
  assign w_grant_id    = p1_req & (~p0_req | ~last_grant_q);
  assign w_grant_we    = w_grant_id ? p1_we    : p0_we;
  assign w_grant_addr  = w_grant_id ? p1_addr  : p0_addr;
  assign w_grant_wdata = w_grant_id ? p1_wdata : p0_wdata;

  // Any address bit above the implemented range flags an error.
  generate
    if (MEM_AW < ADDR_W) begin : g_range_chk
      assign w_addr_err = |w_grant_addr[ADDR_W-1:MEM_AW];
    end else begin : g_no_range_chk
      assign w_addr_err = 1'b0;
    end
  endgenerate

  // State register; asynchronous reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: errors skip straight to the response, writes skip RDWAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (w_any_req) state_d = w_addr_err ? S_RESP : S_ISSUE;
      S_ISSUE:  state_d = cmd_we_q ? S_RESP : S_RDWAIT;
      S_RDWAIT: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs: strobes only in ISSUE, ack/err only in RESP.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_stall = 1'b1;
    p0_ack    = 1'b0;
    p0_err    = 1'b0;
    p1_ack    = 1'b0;
    p1_err    = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_ISSUE: begin
        mem_stall = 1'b0;
        mem_read  = ~cmd_we_q;
        mem_write = cmd_we_q;
      end
      S_RESP: begin
        if (cmd_id_q) begin
          p1_ack = 1'b1;
          p1_err = cmd_err_q;
        end else begin
          p0_ack = 1'b1;
          p0_err = cmd_err_q;
        end
      end
      default: ;
    endcase
  end

  // Command capture at grant; requester changes afterwards are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_id_q     <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_err_q    <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      last_grant_q <= 1'b1;
    end else if (state_q == S_IDLE && w_any_req) begin
      cmd_id_q     <= w_grant_id;
      cmd_we_q     <= w_grant_we;
      cmd_err_q    <= w_addr_err;
      cmd_addr_q   <= w_grant_addr;
      cmd_wdata_q  <= w_grant_wdata;
      last_grant_q <= w_grant_id;
    end
  end

  // Registered read data lands in the winner's rdata; the other port holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else if (state_q == S_RDWAIT) begin
      if (cmd_id_q) p1_rdata_q <= mem_rdata;
      else          p0_rdata_q <= mem_rdata;
    end
  end

  assign mem_addr  = cmd_addr_q;
  assign mem_wdata = cmd_wdata_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a behavioural
//               registered-read memory and a table of directed transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p0_ack, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_ack, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_stall, busy;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_AW(8)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_stall(mem_stall), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Registered-read single-port memory model.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr[7:0]];
  end

  // Strobe/ack monitor sampled on the falling edge.
  int          wr_cnt = 0, rd_cnt = 0, ack1_cnt = 0, dual_ack = 0;
  logic [31:0] last_waddr = '0, last_wdata = '0;
  always @(negedge clk) begin
    if (mem_write) begin
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
    end
    if (mem_read)          rd_cnt   <= rd_cnt + 1;
    if (p1_ack)            ack1_cnt <= ack1_cnt + 1;
    if (p0_ack && p1_ack)  dual_ack <= dual_ack + 1;
  end

  int nvec = 0, nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (!port) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd;
    end
  endtask

  // One transaction from one port; lat stays 0 if no ack arrives in 10 cycles.
  task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic err,
                        output logic [31:0] rd, output int wd_cnt, output int rdc);
    int w0, r0;
    @(negedge clk);
    w0 = wr_cnt; r0 = rd_cnt;
    drive(port, 1'b1, we, addr, wd);
    lat = 0; err = 1'b0; rd = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if ((!port && p0_ack) || (port && p1_ack)) begin
        lat = i;
        err = port ? p1_err : p0_err;
        rd  = port ? p1_rdata : p0_rdata;
        break;
      end
    end
    wd_cnt = wr_cnt - w0;
    rdc    = rd_cnt - r0;
    drive(port, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 14;
  vec_t tv [NV];

  initial begin
    int          lat, nack, idle, wdc, rdc, w0, d0, a1;
    logic        err;
    logic [31:0] rd;
    int          order [4];
    int          ackc [3];

    // port, we, addr, wdata, latency, err, port rdata seen at ack
    tv[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b0, 32'h0000_0000};
    tv[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         3, 1'b0, 32'hDEAD_BEEF};
    tv[2]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_AAAA, 2, 1'b0, 32'h0000_0000};
    tv[3]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         3, 1'b0, 32'h0000_AAAA};
    tv[4]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         1, 1'b1, 32'h0000_AAAA};
    tv[5]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         3, 1'b0, 32'h0000_AAAA};
    tv[6]  = '{1'b0, 1'b1, 32'h0000_0030, 32'h1357_2468, 2, 1'b0, 32'h0000_AAAA};
    tv[7]  = '{1'b0, 1'b1, 32'h0000_00FF, 32'hFFFF_FFFF, 2, 1'b0, 32'h0000_AAAA};
    tv[8]  = '{1'b0, 1'b0, 32'h0000_00FF, 32'h0,         3, 1'b0, 32'hFFFF_FFFF};
    tv[9]  = '{1'b0, 1'b1, 32'h8000_0000, 32'h0BAD_0BAD, 1, 1'b1, 32'hFFFF_FFFF};
    tv[10] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0,         3, 1'b0, 32'h1357_2468};
    tv[11] = '{1'b0, 1'b0, 32'h0000_01FF, 32'h0,         1, 1'b1, 32'hFFFF_FFFF};
    tv[12] = '{1'b1, 1'b1, 32'h0000_0110, 32'h1111_1111, 1, 1'b1, 32'h1357_2468};
    tv[13] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         3, 1'b0, 32'hDEAD_BEEF};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst busy",      32'(busy), 32'd0);
    check("rst acks/errs", {28'd0, p0_ack, p0_err, p1_ack, p1_err}, 32'd0);
    check("rst strobes",   {29'd0, mem_read, mem_write, mem_stall}, 32'd1);
    check("rst mem_addr",  mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst p0_rdata",  p0_rdata, 32'd0);
    check("rst p1_rdata",  p1_rdata, 32'd0);

    // Single-port directed transactions
    for (int k = 0; k < NV; k++) begin
      do_txn(tv[k].port, tv[k].we, tv[k].addr, tv[k].wdata, lat, err, rd, wdc, rdc);
      check($sformatf("v%0d latency", k), lat, tv[k].lat);
      check($sformatf("v%0d err", k), 32'(err), 32'(tv[k].err));
      check($sformatf("v%0d rdata", k), rd, tv[k].rdata);
      check($sformatf("v%0d write strobes", k), wdc, (tv[k].we && !tv[k].err) ? 1 : 0);
      check($sformatf("v%0d read strobes", k), rdc, (!tv[k].we && !tv[k].err) ? 1 : 0);
      if (tv[k].we && !tv[k].err) begin
        check($sformatf("v%0d write addr", k), last_waddr, tv[k].addr);
        check($sformatf("v%0d write data", k), last_wdata, tv[k].wdata);
      end
    end

    // Requester changes addr/wdata during ISSUE: the latched command wins
    @(negedge clk);
    w0 = wr_cnt;
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h5555);
    @(negedge clk);
    check("hold issue mem_write", 32'(mem_write), 32'd1);
    check("hold issue mem_addr", mem_addr, 32'h10);
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h1234);
    nack = 0;
    for (int i = 0; i < 10 && nack == 0; i++) begin
      @(negedge clk);
      if (p0_ack) nack = 1;
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check("hold ack seen", nack, 1);
    check("hold write count", wr_cnt - w0, 1);
    check("hold write addr", last_waddr, 32'h10);
    check("hold write data", last_wdata, 32'h5555);
    do_txn(1'b0, 1'b0, 32'h10, '0, lat, err, rd, wdc, rdc);
    check("hold readback 0x10", rd, 32'h5555);
    do_txn(1'b0, 1'b0, 32'h20, '0, lat, err, rd, wdc, rdc);
    check("hold readback 0x20", rd, 32'h0000_AAAA);

    // Reset during ISSUE of a port-1 write to 0x30
    @(negedge clk);
    a1 = ack1_cnt;
    drive(1'b1, 1'b1, 1'b1, 32'h30, 32'hBAD0_BAD0);
    @(negedge clk);
    check("rstmid busy in issue", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid mem_write", 32'(mem_write), 32'd0);
    check("rstmid busy", 32'(busy), 32'd0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid no p1 ack", ack1_cnt - a1, 0);
    check("rstmid busy after", 32'(busy), 32'd0);
    do_txn(1'b0, 1'b0, 32'h30, '0, lat, err, rd, wdc, rdc);
    check("rstmid readback 0x30", rd, 32'h1357_2468);

    // Simultaneous requests held: grant order alternates from port 0
    pulse_reset();
    @(negedge clk);
    d0 = dual_ack;
    drive(1'b0, 1'b1, 1'b0, 32'h10, '0);
    drive(1'b1, 1'b1, 1'b0, 32'h20, '0);
    nack = 0;
    for (int i = 0; i < 40 && nack < 4; i++) begin
      @(negedge clk);
      if (p0_ack)      begin order[nack] = 0; nack++; end
      else if (p1_ack) begin order[nack] = 1; nack++; end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    check("rr ack count", nack, 4);
    for (int i = 0; i < 4; i++) check($sformatf("rr grant %0d", i), order[i], i % 2);
    @(negedge clk);
    check("rr dual ack", dual_ack - d0, 0);
    check("rr p0 rdata", p0_rdata, 32'h5555);
    check("rr p1 rdata", p1_rdata, 32'h0000_AAAA);
    check("rr busy after", 32'(busy), 32'd0);

    // Port 0 holds req for three back-to-back writes
    @(negedge clk);
    w0 = wr_cnt;
    drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h77);
    nack = 0; idle = 0;
    for (int i = 1; i <= 40 && nack < 3; i++) begin
      @(negedge clk);
      if (p0_ack)     begin ackc[nack] = i; nack++; end
      else if (!busy) idle++;
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check("b2b ack count", nack, 3);
    check("b2b first ack", ackc[0], 2);
    check("b2b spacing 1", ackc[1] - ackc[0], 3);
    check("b2b spacing 2", ackc[2] - ackc[1], 3);
    check("b2b idle cycles", idle, 2);
    @(negedge clk);
    check("b2b write count", wr_cnt - w0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
